// File: rtl/vga_pixel_sink.sv
// Pixel write buffer and framebuffer port arbiter: scan-out reads, full-frame clear, buffered plots.
// Optional macro PIXEL_BOUNDS_CHECK_EN discards off-screen pixels instead of writing them.
module vga_pixel_sink #(
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [2:0]  color,
    input  logic        plot,
    output logic        ready,
    input  logic        clear,
    input  logic [2:0]  clear_color,
    output logic        busy,
    input  logic        scan_req,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_wdata,
    output logic        mem_we,
    output logic        frame_done
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [14:0] LAST_ADDR = 15'(SCREEN_W * SCREEN_H - 1);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    state_t           state_q;
    logic [14:0]      scan_q;
    logic [14:0]      clr_q;
    logic [2:0]       clr_color_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [17:0]      fifo_mem [FIFO_DEPTH];

    logic        fifo_empty;
    logic        fifo_full;
    logic        in_bounds;
    logic        push;
    logic        pop;
    logic        clr_grant;
    logic [14:0] pix_addr;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign pix_addr   = 15'(32'(y) * 32'(SCREEN_W) + 32'(x));

`ifdef PIXEL_BOUNDS_CHECK_EN
    assign in_bounds = (32'(x) < 32'(SCREEN_W)) && (32'(y) < 32'(SCREEN_H));
`else
    assign in_bounds = 1'b1;
`endif

    // Off-screen pixels are still handshaken so the drawing datapath never stalls on them.
    assign ready      = resetn && !fifo_full && (state_q == IDLE);
    assign push       = plot && ready && in_bounds;
    assign clr_grant  = !scan_req && (state_q == CLEAR);
    assign pop        = !scan_req && (state_q != CLEAR) && !fifo_empty;
    assign busy       = (state_q != IDLE);
    assign frame_done = resetn && scan_req && (scan_q == LAST_ADDR);

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (scan_req) begin
            mem_addr = scan_q;
        end else if (clr_grant) begin
            mem_we    = 1'b1;
            mem_addr  = clr_q;
            mem_wdata = clr_color_q;
        end else if (pop) begin
            mem_we                = 1'b1;
            {mem_addr, mem_wdata} = fifo_mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {pix_addr, color};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            scan_q      <= '0;
            clr_q       <= '0;
            clr_color_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            if (scan_req) begin
                scan_q <= (scan_q == LAST_ADDR) ? '0 : scan_q + 15'd1;
            end
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CNT_W'(1);
            end

            // Pixels accepted before or with the clear pulse must land before the fill overwrites.
            case (state_q)
                IDLE: begin
                    if (clear) begin
                        state_q     <= DRAIN;
                        clr_color_q <= clear_color;
                        clr_q       <= '0;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state_q <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (clr_grant) begin
                        if (clr_q == LAST_ADDR) begin
                            clr_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            clr_q <= clr_q + 15'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_pixel_sink.sv
// Bench for vga_pixel_sink: directed scenarios and randomized plotting checked against
// a queue model of the expected framebuffer traffic.
module tb_vga_pixel_sink;
    localparam int W     = 160;
    localparam int H     = 120;
    localparam int NPIX  = W * H;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  color;
    logic        plot;
    logic        ready;
    logic        clear;
    logic [2:0]  clear_color;
    logic        busy;
    logic        scan_req;
    logic [14:0] mem_addr;
    logic [2:0]  mem_wdata;
    logic        mem_we;
    logic        frame_done;

    vga_pixel_sink #(.SCREEN_W(W), .SCREEN_H(H), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .x(x), .y(y), .color(color), .plot(plot),
        .ready(ready), .clear(clear), .clear_color(clear_color), .busy(busy),
        .scan_req(scan_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int testCount = 0;
    int failCount = 0;
    int expQ[$];
    int scanCnt = 0;
    bit modelBusy = 1'b0;
    logic        obsWe;
    logic        obsReady;
    logic        obsFrame;
    logic [14:0] obsAddr;

    task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit p, input int px, input int py, input int pc,
                                 input bit c, input int cc, input bit s);
        plot        = p;
        x           = 8'(px);
        y           = 7'(py);
        color       = 3'(pc);
        clear       = c;
        clear_color = 3'(cc);
        scan_req    = s;
    endtask

    task automatic checkOutput();
        @(negedge clk);
        obsWe    = mem_we;
        obsAddr  = mem_addr;
        obsReady = ready;
        obsFrame = frame_done;
        checkEq("busy", busy, modelBusy);
        checkEq("ready", ready, !modelBusy && expQ.size() < DEPTH);
        if (scan_req) begin
            checkEq("scanWe", mem_we, 0);
            checkEq("scanAddr", mem_addr, scanCnt);
            checkEq("frameDone", frame_done, scanCnt == NPIX - 1);
        end else begin
            checkEq("frameDoneIdle", frame_done, 0);
            if (modelBusy && !mem_we) begin
                checkEq("gapAddr", mem_addr, 0);
            end else if (expQ.size() == 0) begin
                checkEq("idleWe", mem_we, 0);
                checkEq("idleAddr", mem_addr, 0);
            end else begin
                checkEq("writeWe", mem_we, 1);
                checkEq("writeAddr", mem_addr, expQ[0] >> 3);
                checkEq("writeData", mem_wdata, expQ[0] & 7);
            end
        end
    endtask

    // Model step at the clock edge: one grant per cycle, then accept plot, then sample clear.
    task automatic advance();
        int  sizeBefore;
        bit  busyBefore;
        int  addr;
        @(posedge clk);
        sizeBefore = expQ.size();
        busyBefore = modelBusy;
        if (scan_req) begin
            scanCnt = (scanCnt + 1) % NPIX;
        end else if (busyBefore ? obsWe : (sizeBefore > 0)) begin
            if (expQ.size() > 0) void'(expQ.pop_front());
            if (busyBefore && expQ.size() == 0) modelBusy = 1'b0;
        end
        if (plot && !busyBefore && sizeBefore < DEPTH) begin
            addr = (int'(y) * W + int'(x)) % 32768;
`ifdef PIXEL_BOUNDS_CHECK_EN
            if (int'(x) < W && int'(y) < H) expQ.push_back(addr * 8 + int'(color));
`else
            expQ.push_back(addr * 8 + int'(color));
`endif
        end
        if (clear && !busyBefore) begin
            for (int a = 0; a < NPIX; a++) expQ.push_back(a * 8 + int'(clear_color));
            modelBusy = 1'b1;
        end
        #1;
    endtask

    task automatic cycle();
        checkOutput();
        advance();
    endtask

    task automatic modelReset();
        expQ.delete();
        scanCnt   = 0;
        modelBusy = 1'b0;
    endtask

    initial begin
        int n;
        int writes;
        int frameCount;
        bit found;

        resetn = 1'b0;
        applyStimulus(1, 3, 4, 5, 1, 2, 0);
        @(negedge clk);
        checkEq("rstReady", ready, 0);
        checkEq("rstBusy", busy, 0);
        checkEq("rstWe", mem_we, 0);
        checkEq("rstAddr", mem_addr, 0);
        checkEq("rstData", mem_wdata, 0);
        checkEq("rstFrame", frame_done, 0);
        @(posedge clk);
        #1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        resetn = 1'b1;

        applyStimulus(1, 5, 2, 5, 0, 0, 0);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput();
        checkEq("req035We", obsWe, 1);
        checkEq("req035Addr", obsAddr, 325);
        checkEq("req035Data", mem_wdata, 3'b101);
        advance();

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, $urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(0, 7), 0, 0, 1);
            cycle();
            if (i == 4) checkEq("req036ReadyLow", obsReady, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            checkEq("req036We", obsWe, 1);
        end
        cycle();

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 127),
                          $urandom_range(0, 7), 0, 0, $urandom_range(0, 9) < 3);
            cycle();
        end

        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && expQ.size() > 0; i++) cycle();

        applyStimulus(1, $urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(0, 7), 0, 0, 1);
        cycle();
        applyStimulus(1, $urandom_range(0, W - 1), $urandom_range(0, H - 1), $urandom_range(0, 7), 1, 1, 1);
        cycle();
        n = 0;
        writes = 0;
        while (modelBusy && n < 30000) begin
            applyStimulus($urandom_range(0, 1), $urandom_range(0, W - 1), $urandom_range(0, H - 1),
                          $urandom_range(0, 7), $urandom_range(0, 63) == 0, $urandom_range(0, 7),
                          $urandom_range(0, 7) == 0);
            cycle();
            if (obsWe) writes++;
            n++;
        end
        if (modelBusy) begin
            testCount++;
            failCount++;
            $error("[TB] FAIL clearTimeout observed=busy expected=idle");
        end
        checkEq("req037WriteCount", writes, NPIX + 2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        cycle();

        applyStimulus(0, 0, 0, 0, 1, 6, 0);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            checkOutput();
            if (obsWe && obsAddr == 15'd500 && modelBusy) found = 1'b1;
            else advance();
        end
        if (!found) begin
            testCount++;
            failCount++;
            $error("[TB] FAIL req040Reach observed=no_addr_500 expected=addr_500");
        end
        resetn = 1'b0;
        #1;
        checkEq("req040We", mem_we, 0);
        checkEq("req040Busy", busy, 0);
        checkEq("req040Ready", ready, 0);
        modelReset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        writes = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (obsWe) writes++;
        end
        checkEq("req040NoWrites", writes, 0);

        frameCount = 0;
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < NPIX; i++) begin
            cycle();
            checkEq("req038Addr", obsAddr, i);
            if (obsFrame) begin
                frameCount++;
                checkEq("req038FrameAddr", obsAddr, NPIX - 1);
            end
        end
        checkEq("req038FrameCount", frameCount, 1);
        cycle();
        checkEq("req038Wrap", obsAddr, 0);

        applyStimulus(1, 200, 10, 3, 0, 0, 0);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput();
`ifdef PIXEL_BOUNDS_CHECK_EN
        checkEq("req039NoWrite", obsWe, 0);
`else
        checkEq("req039We", obsWe, 1);
        checkEq("req039Addr", obsAddr, 1800);
`endif
        advance();

        for (int i = 0; i < 200; i++) begin
            applyStimulus($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 127),
                          $urandom_range(0, 7), 0, 0, $urandom_range(0, 9) < 5);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
